// File: rtl/uart_rx_oversampled_if.sv
// Serial-in / byte-out bundle of the oversampling UART receiver.
// master drives the line and observes the results; slave is the receiver.
interface uart_rx_oversampled_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  serial_in;
    logic [DATA_WIDTH-1:0] received_data;
    logic                  data_is_valid;
    logic                  rx_error;
    logic                  o_busy;

    modport master (
        output serial_in,
        input  received_data,
        input  data_is_valid,
        input  rx_error,
        input  o_busy
    );

    modport slave (
        input  serial_in,
        output received_data,
        output data_is_valid,
        output rx_error,
        output o_busy
    );
endinterface

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver, CLOCKS_PER_BIT clocks per bit, 3-sample mid-bit majority vote.
// Optional even-parity bit when UART_RX_PARITY_EN is defined.
module uart_rx_oversampled #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int CLOCKS_PER_BIT   = 8
) (
    input logic                  clk,
    input logic                  reset,
    uart_rx_oversampled_if.slave rx
);
    localparam int H     = CLOCKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam int IDX_W = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;

    // Samples land on the edges where baud_cnt advances to H-1, H and H+1;
    // the third edge is also the decision edge.
    localparam logic [CNT_W-1:0] CNT_SAMPLE0 = CNT_W'(H - 2);
    localparam logic [CNT_W-1:0] CNT_SAMPLE1 = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_DECIDE  = CNT_W'(H);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(INPUT_DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                      state, state_next;
    logic                        sync1, sync2;
    logic [CNT_W-1:0]            baud_cnt, cnt_next;
    logic [IDX_W-1:0]            bit_idx, idx_next;
    logic                        samp0, samp1;
    logic [INPUT_DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [INPUT_DATA_WIDTH-1:0] data_q, data_next;
    logic                        valid_q, valid_next;
    logic                        err_q, err_next;
    logic                        majority, at_decide, at_bit_end, frame_ok;

    assign at_decide  = (baud_cnt == CNT_DECIDE);
    assign at_bit_end = (baud_cnt == CNT_LAST);
    assign majority   = (samp0 & samp1) | (samp0 & sync2) | (samp1 & sync2);

`ifdef UART_RX_PARITY_EN
    logic parity_bit, parity_next;
    assign frame_ok = majority && !(^shift_reg ^ parity_bit);
`else
    assign frame_ok = majority;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next = state;
        cnt_next   = at_bit_end ? '0 : baud_cnt + CNT_W'(1);
        idx_next   = bit_idx;
        shift_next = shift_reg;
        data_next  = data_q;
        valid_next = 1'b0;
        err_next   = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_next = parity_bit;
`endif
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!sync2) state_next = START;
            end
            START: begin
                if (at_decide && majority) begin
                    state_next = IDLE;
                end else if (at_bit_end) begin
                    state_next = DATA;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (at_decide) shift_next[bit_idx] = majority;
                if (at_bit_end) begin
                    if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_decide) parity_next = majority;
                if (at_bit_end) state_next = STOP;
            end
`endif
            STOP: begin
                // Act at the stop decision instead of waiting out the stop bit.
                if (at_decide) begin
                    if (frame_ok) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                    state_next = majority ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                cnt_next = '0;
                if (sync2) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            samp0     <= 1'b1;
            samp1     <= 1'b1;
            shift_reg <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            sync1     <= rx.serial_in;
            sync2     <= sync1;
            state     <= state_next;
            baud_cnt  <= cnt_next;
            bit_idx   <= idx_next;
            shift_reg <= shift_next;
            data_q    <= data_next;
            valid_q   <= valid_next;
            err_q     <= err_next;
`ifdef UART_RX_PARITY_EN
            parity_bit <= parity_next;
`endif
            if (baud_cnt == CNT_SAMPLE0) samp0 <= sync2;
            if (baud_cnt == CNT_SAMPLE1) samp1 <= sync2;
        end
    end

    assign rx.received_data = data_q;
    assign rx.data_is_valid = valid_q;
    assign rx.rx_error      = err_q;
    assign rx.o_busy        = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: a frame-level model predicts every pulse and byte,
// checked each cycle on the falling edge; literal checks pin latency and spacing.
module tb_uart_rx_oversampled;
    localparam int W   = 8;
    localparam int CPB = 8;
    localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int LAT   = 87;
    localparam int FRAME = 88;
`else
    localparam int LAT   = 79;
    localparam int FRAME = 80;
`endif

    logic clk = 1'b0;
    logic reset;

    uart_rx_oversampled_if #(.DATA_WIDTH(W)) rif ();

    uart_rx_oversampled #(
        .INPUT_DATA_WIDTH(W),
        .CLOCKS_PER_BIT  (CPB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rx   (rif)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    bit         run_checks = 1'b0;
    logic [7:0] exp_valid [int];
    bit         exp_err [int];
    logic [7:0] model_data = 8'h00;
    int         valid_q [$];
    logic [7:0] vdata_q [$];
    int         err_cnt = 0;
    int         last_e0 = 0;
`ifdef UART_RX_PARITY_EN
    bit         flip_parity = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: a frame whose start reaches sync1 at edge e0 produces its pulse right after edge e0+LAT.
    always @(negedge clk) begin
        bit ev_v;
        bit ev_e;
        if (run_checks && !reset) begin
            ev_v = exp_valid.exists(cyc);
            ev_e = exp_err.exists(cyc);
            if (ev_v) model_data = exp_valid[cyc];
            check("data_is_valid", rif.data_is_valid, ev_v);
            check("rx_error", rif.rx_error, ev_e);
            check("received_data", rif.received_data, model_data);
            if (rif.data_is_valid === 1'b1) begin
                valid_q.push_back(cyc);
                vdata_q.push_back(rif.received_data);
            end
            if (rif.rx_error === 1'b1) err_cnt++;
        end
    end

    task automatic send_frame(input logic [7:0] data, input int stop_low);
        int e0;
        bit ok;
        e0      = cyc + 1;
        last_e0 = e0;
        ok      = (stop_low == 0);
`ifdef UART_RX_PARITY_EN
        ok = ok && !flip_parity;
`endif
        if (ok) exp_valid[e0 + LAT] = data;
        else    exp_err[e0 + LAT]   = 1'b1;

        rif.serial_in = 1'b0;
        tick(2);
        check("busy_before_detect", rif.o_busy, 1'b0);
        tick(1);
        check("busy_after_detect", rif.o_busy, 1'b1);
        tick(CPB - 3);
        for (int i = 0; i < W; i++) begin
            rif.serial_in = data[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rif.serial_in = ^data ^ flip_parity;
        tick(CPB);
`endif
        if (stop_low == 0) begin
            rif.serial_in = 1'b1;
            tick(CPB);
        end else begin
            rif.serial_in = 1'b0;
            tick(stop_low);
            rif.serial_in = 1'b1;
        end
    endtask

    initial begin
        int busy_cycles;
        int err_before;
        logic [7:0] abort_byte;

        rif.serial_in = 1'b1;
        reset         = 1'b1;
        tick(2);
        reset      = 1'b0;
        run_checks = 1'b1;

        // Idle after reset
        check("reset_received_data", rif.received_data, 8'h00);
        check("reset_busy", rif.o_busy, 1'b0);
        for (int i = 0; i < 200; i++) begin
            tick(1);
            check("idle_busy", rif.o_busy, 1'b0);
        end

        // Good frame
        valid_q.delete();
        send_frame(8'hA5, 0);
        tick(5);
        check("good_pulse_count", valid_q.size(), 1);
        check("good_latency", valid_q[0] - last_e0, LAT);
        check("good_data", rif.received_data, 8'hA5);

        // False start: 2-cycle glitch
        tick(20);
        rif.serial_in = 1'b0;
        tick(2);
        rif.serial_in = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (rif.o_busy === 1'b1) busy_cycles++;
        end
        check("false_start_seen", busy_cycles > 0, 1);
        check("false_start_busy_bound", busy_cycles <= H + 2, 1);
        check("false_start_idle", rif.o_busy, 1'b0);

        // Framing error: 0x3C with stop held low for 30 cycles
        err_before = err_cnt;
        send_frame(8'h3C, 30);
        check("framing_busy_held", rif.o_busy, 1'b1);
        check("framing_err_pulses", err_cnt - err_before, 1);
        check("framing_keeps_data", rif.received_data, 8'hA5);
        tick(3);
        check("framing_busy_released", rif.o_busy, 1'b0);

        // Back-to-back frames
        tick(20);
        valid_q.delete();
        vdata_q.delete();
        send_frame(8'h00, 0);
        send_frame(8'hFF, 0);
        tick(10);
        check("b2b_pulse_count", valid_q.size(), 2);
        check("b2b_spacing", valid_q[1] - valid_q[0], FRAME);
        check("b2b_first_data", vdata_q[0], 8'h00);
        check("b2b_second_data", vdata_q[1], 8'hFF);

        // Reset during data bit 4 of an aborted frame
        tick(20);
        abort_byte    = 8'h3C;
        rif.serial_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rif.serial_in = abort_byte[i];
            tick(CPB);
        end
        rif.serial_in = abort_byte[4];
        tick(3);
        reset         = 1'b1;
        rif.serial_in = 1'b1;
        exp_valid.delete();
        exp_err.delete();
        model_data = 8'h00;
        tick(2);
        reset = 1'b0;
        check("midreset_data_cleared", rif.received_data, 8'h00);
        check("midreset_busy_cleared", rif.o_busy, 1'b0);
        tick(20);

        valid_q.delete();
        err_before = err_cnt;
`ifdef UART_RX_PARITY_EN
        flip_parity = 1'b1;
        send_frame(8'h5A, 0);
        flip_parity = 1'b0;
        tick(10);
        check("odd_parity_err", err_cnt - err_before, 1);
        check("odd_parity_no_valid", valid_q.size(), 0);
        check("odd_parity_data", rif.received_data, 8'h00);
`else
        send_frame(8'h5A, 0);
        tick(10);
        check("after_reset_pulse_count", valid_q.size(), 1);
        check("after_reset_data", rif.received_data, 8'h5A);
        check("after_reset_no_err", err_cnt - err_before, 0);
`endif

        tick(50);
        run_checks = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
